// File: rtl/ahb_apb4_bridge_mux_pkg.sv
// rtl/ahb_apb4_bridge_mux_pkg.sv - shared AHB/APB types, FSM states and byte-strobe helper
// Purpose: common definitions for the AHB-Lite to APB4 multi-slave bridge.
// Contents: htrans_t, HRESP_OKAY/HRESP_ERROR, bridge_state_t, strb_gen().
package ahb_apb4_bridge_mux_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } bridge_state_t;

   // Byte strobes for a transfer of 2**hsize bytes at byte lane addr_lsb.
   // The lane offset is rounded down to the transfer size so a misaligned
   // address still yields a contiguous, size-aligned mask.
   function automatic logic [7:0] strb_gen(input logic [2:0] hsize,
                                           input logic [2:0] addr_lsb);
      logic [7:0] mask;
      logic [2:0] aligned;
      case (hsize)
         3'd0:    mask = 8'h01;
         3'd1:    mask = 8'h03;
         3'd2:    mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      aligned = addr_lsb & ~((3'd1 << hsize) - 3'd1);
      return mask << aligned;
   endfunction

endpackage

// File: rtl/ahb_apb4_bridge_mux_if.sv
// rtl/ahb_apb4_bridge_mux_if.sv - AHB-Lite slave side and APB4 multi-slave side of the bridge
// Purpose: bundles the AHB and APB bus signals of the bridge.
// Modports: slave  - bridge view (AHB inputs, APB outputs, APB slave responses in)
//           master - environment view (drives AHB requests and APB slave responses)
interface ahb_apb4_bridge_mux_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4
);
   logic                             HSEL;
   logic [ADDR_WIDTH-1:0]            HADDR;
   logic [1:0]                       HTRANS;
   logic                             HWRITE;
   logic [2:0]                       HSIZE;
   logic [3:0]                       HPROT;
   logic                             HREADY_IN;
   logic [DATA_WIDTH-1:0]            HWDATA;
   logic [DATA_WIDTH-1:0]            HRDATA;
   logic                             HRESP;
   logic                             HREADY_OUT;
   logic [NUM_SLAVES-1:0]            PSEL;
   logic                             PENABLE;
   logic [ADDR_WIDTH-1:0]            PADDR;
   logic                             PWRITE;
   logic [DATA_WIDTH-1:0]            PWDATA;
   logic [DATA_WIDTH/8-1:0]          PSTRB;
   logic [2:0]                       PPROT;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]            PREADY;
   logic [NUM_SLAVES-1:0]            PSLVERR;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY_IN, HWDATA,
      input  PRDATA, PREADY, PSLVERR,
      output HRDATA, HRESP, HREADY_OUT,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY_IN, HWDATA,
      output PRDATA, PREADY, PSLVERR,
      input  HRDATA, HRESP, HREADY_OUT,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT
   );

endinterface

// File: rtl/ahb_apb4_bridge_mux_apb_slave_mux.sv
// rtl/ahb_apb4_bridge_mux_apb_slave_mux.sv - slave index decode and APB response mux
// Purpose: turns the latched slave index into a one-hot select and picks the
//          addressed slave's PRDATA/PREADY/PSLVERR. Purely combinational.
// Ports: idx in; prdata_all/pready_all/pslverr_all in (all slaves);
//        psel_onehot, prdata, pready, pslverr out (selected slave).
module apb_slave_mux #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter int IDX_W      = 2
) (
   input  logic [IDX_W-1:0]                 idx,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_all,
   input  logic [NUM_SLAVES-1:0]            pready_all,
   input  logic [NUM_SLAVES-1:0]            pslverr_all,
   output logic [NUM_SLAVES-1:0]            psel_onehot,
   output logic [DATA_WIDTH-1:0]            prdata,
   output logic                             pready,
   output logic                             pslverr
);

   always_comb begin
      psel_onehot = '0;
      prdata      = '0;
      pready      = 1'b0;
      pslverr     = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (int'(idx) == i) begin
            psel_onehot[i] = 1'b1;
            prdata         = prdata_all[i*DATA_WIDTH +: DATA_WIDTH];
            pready         = pready_all[i];
            pslverr        = pslverr_all[i];
         end
      end
   end

endmodule

// File: rtl/ahb_apb4_bridge_mux.sv
// rtl/ahb_apb4_bridge_mux.sv - AHB-Lite slave to APB4 master bridge with per-slave PSEL
// Purpose: converts one AHB-Lite transfer at a time into an APB4 SETUP/ACCESS
//          sequence on one of NUM_SLAVES slaves, with wait states, slave error
//          and PREADY timeout mapped onto the two-cycle AHB ERROR response.
// Ports: HCLK, HRESETn (async, active-low); bus (slave modport) carrying the
//        AHB request/response and the APB select/control/data signals.
module ahb_apb4_bridge_mux
   import ahb_apb4_bridge_mux_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_SLAVES  = 4,
   parameter int SLV_SEL_LSB = 12,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ahb_apb4_bridge_mux_if.slave bus
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int LSB_W    = $clog2(STRB_W);
   localparam int IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int REGION_W = ADDR_WIDTH - SLV_SEL_LSB;
   localparam int TCNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam bit TO_EN    = (TIMEOUT_CYC > 0);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   bridge_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
   logic                    hwrite_q, hwrite_d;
   logic [2:0]              hsize_q, hsize_d;
   logic [1:0]              hprot_q, hprot_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    in_range_q, in_range_d;
   logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
   logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
   logic                    hresp_q, hresp_d;
   logic                    hready_q, hready_d;
   logic [NUM_SLAVES-1:0]   psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]       pstrb_q, pstrb_d;
   logic [2:0]              pprot_q, pprot_d;

   logic                    valid;
   logic [REGION_W-1:0]     region;
   logic                    size_ok;
   logic [2:0]              addr_lsb;
   logic [7:0]              strb_full;
   logic [NUM_SLAVES-1:0]   sel_onehot;
   logic [DATA_WIDTH-1:0]   mux_prdata;
   logic                    mux_pready;
   logic                    mux_pslverr;
   logic                    unused_ok;

   assign valid = bus.HSEL & bus.HTRANS[1] & bus.HREADY_IN;

   // The whole address above SLV_SEL_LSB is the region number, so addresses
   // past the last slave decode as out of range instead of aliasing.
   assign region   = bus.HADDR[ADDR_WIDTH-1:SLV_SEL_LSB];
   assign size_ok  = (32'd8 << hsize_q) <= 32'(DATA_WIDTH);
   assign addr_lsb = 3'(haddr_q[LSB_W-1:0]);
   assign strb_full = strb_gen(hsize_q, addr_lsb);
   assign unused_ok = ^{bus.HPROT[3:2], bus.HTRANS[0], strb_full};

   apb_slave_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_SLAVES (NUM_SLAVES),
      .IDX_W      (IDX_W)
   ) u_apb_slave_mux (
      .idx         (idx_q),
      .prdata_all  (bus.PRDATA),
      .pready_all  (bus.PREADY),
      .pslverr_all (bus.PSLVERR),
      .psel_onehot (sel_onehot),
      .prdata      (mux_prdata),
      .pready      (mux_pready),
      .pslverr     (mux_pslverr)
   );

   // Every output is registered, so each branch sets the output values that
   // belong to the state being entered.
   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      hwrite_d   = hwrite_q;
      hsize_d    = hsize_q;
      hprot_d    = hprot_q;
      idx_d      = idx_q;
      in_range_d = in_range_q;
      tcnt_d     = tcnt_q;
      hrdata_d   = hrdata_q;
      hresp_d    = hresp_q;
      hready_d   = hready_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      paddr_d    = paddr_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      pstrb_d    = pstrb_q;
      pprot_d    = pprot_q;

      case (state_q)
         // ERR2 is the last cycle of the error response and already shows
         // HREADY_OUT=1, so a new address phase is accepted exactly as in IDLE.
         ST_IDLE, ST_ERR2: begin
            state_d  = ST_IDLE;
            hresp_d  = HRESP_OKAY;
            hready_d = 1'b1;
            if (valid) begin
               state_d    = ST_LATCH;
               hready_d   = 1'b0;
               haddr_d    = bus.HADDR;
               hwrite_d   = bus.HWRITE;
               hsize_d    = bus.HSIZE;
               hprot_d    = bus.HPROT[1:0];
               idx_d      = region[IDX_W-1:0];
               in_range_d = region < REGION_W'(NUM_SLAVES);
            end
         end

         ST_LATCH: begin
            if (!in_range_q || !size_ok) begin
               state_d = ST_ERR1;
               hresp_d = HRESP_ERROR;
            end else begin
               state_d  = ST_SETUP;
               psel_d   = sel_onehot;
               paddr_d  = haddr_q;
               pwrite_d = hwrite_q;
               pwdata_d = bus.HWDATA;
               pstrb_d  = hwrite_q ? strb_full[STRB_W-1:0] : '0;
               pprot_d  = {~hprot_q[0], 1'b0, hprot_q[1]};
            end
         end

         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end

         ST_ACCESS: begin
            if (mux_pready) begin
               psel_d    = '0;
               penable_d = 1'b0;
               tcnt_d    = '0;
               if (!pwrite_q) begin
                  hrdata_d = mux_prdata;
               end
               if (mux_pslverr) begin
                  state_d = ST_ERR1;
                  hresp_d = HRESP_ERROR;
               end else begin
                  state_d  = ST_IDLE;
                  hresp_d  = HRESP_OKAY;
                  hready_d = 1'b1;
               end
            end else if (TO_EN && (tcnt_q == TCNT_LAST)) begin
               // Slave never answered: abandon the APB access and report ERROR.
               psel_d    = '0;
               penable_d = 1'b0;
               tcnt_d    = '0;
               state_d   = ST_ERR1;
               hresp_d   = HRESP_ERROR;
            end else if (TO_EN) begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         ST_ERR1: begin
            state_d  = ST_ERR2;
            hresp_d  = HRESP_ERROR;
            hready_d = 1'b1;
         end

         default: begin
            state_d   = ST_IDLE;
            hresp_d   = HRESP_OKAY;
            hready_d  = 1'b1;
            psel_d    = '0;
            penable_d = 1'b0;
            tcnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         haddr_q    <= '0;
         hwrite_q   <= 1'b0;
         hsize_q    <= '0;
         hprot_q    <= '0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         tcnt_q     <= '0;
         hrdata_q   <= '0;
         hresp_q    <= HRESP_OKAY;
         hready_q   <= 1'b1;
         psel_q     <= '0;
         penable_q  <= 1'b0;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         pprot_q    <= '0;
      end else begin
         state_q    <= state_d;
         haddr_q    <= haddr_d;
         hwrite_q   <= hwrite_d;
         hsize_q    <= hsize_d;
         hprot_q    <= hprot_d;
         idx_q      <= idx_d;
         in_range_q <= in_range_d;
         tcnt_q     <= tcnt_d;
         hrdata_q   <= hrdata_d;
         hresp_q    <= hresp_d;
         hready_q   <= hready_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         paddr_q    <= paddr_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         pstrb_q    <= pstrb_d;
         pprot_q    <= pprot_d;
      end
   end

   assign bus.HRDATA     = hrdata_q;
   assign bus.HRESP      = hresp_q;
   assign bus.HREADY_OUT = hready_q;
   assign bus.PSEL       = psel_q;
   assign bus.PENABLE    = penable_q;
   assign bus.PADDR      = paddr_q;
   assign bus.PWRITE     = pwrite_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.PSTRB      = pstrb_q;
   assign bus.PPROT      = pprot_q;

endmodule
